regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-side controller for the 32x32 register file's single write port (we/waddr/wdata).
//  Merges two result sources into that port:
//   - ALU pipeline: always accepted, highest priority.
//   - Long-latency unit (LSU/mul-div): valid/ready handshake, buffered in a small FIFO.
//  Provides pending-write flags so ID can stall reads of registers whose queued write has not landed.
// PARAMETERS
//  DATA_W  32  width of wdata and result data (matches `RegBus)
//  ADDR_W  5   register address width (matches `RegNumLog2)
//  DEPTH   4   LSU result FIFO entries; power of two, >=2
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  alu_valid  in   1       ALU result present this cycle
//  alu_waddr  in   ADDR_W  ALU destination register
//  alu_wdata  in   DATA_W  ALU result
//  lsu_valid  in   1       LSU result offered
//  lsu_ready  out  1       controller accepts LSU result (transfer = valid & ready)
//  lsu_waddr  in   ADDR_W  LSU destination register
//  lsu_wdata  in   DATA_W  LSU result
//  raddr1     in   ADDR_W  ID read address, port 1
//  raddr2     in   ADDR_W  ID read address, port 2
//  pend1      out  1       queued write pending for raddr1
//  pend2      out  1       queued write pending for raddr2
//  we         out  1       register-file write enable (registered)
//  waddr      out  ADDR_W  register-file write address (registered)
//  wdata      out  DATA_W  register-file write data (registered)
// BEHAVIOUR
//  - Reset: we=0, waddr=0, wdata=0, FIFO emptied (all entries discarded, incl. mid-drain),
//    lsu_ready=0 while rst=1, pend1=pend2=0.
//  - FIFO entry = {live, addr, data}. lsu_ready = !rst & !full. No same-cycle pop->push bypass when full.
//  - Push on lsu_valid & lsu_ready. An LSU result with lsu_waddr==0 is accepted but not enqueued.
//  - Output select, evaluated each cycle, registered at the next clk edge:
//     1. alu_valid & alu_waddr!=0 -> we=1, waddr=alu_waddr, wdata=alu_wdata; FIFO does not pop.
//     2. else if FIFO non-empty -> pop head; we=head.live, waddr/wdata from head.
//     3. else -> we=0; waddr/wdata hold their last value.
//  - alu_valid with alu_waddr==0 counts as "no ALU write"; the FIFO may pop that cycle.
//  - Latency: ALU result -> we one cycle later. LSU result -> we >=2 cycles after acceptance
//    (enqueue cycle + pop cycle), plus one cycle per ALU write that wins priority.
//  - Ordering: an ALU result is always younger than every queued LSU result.
//    On an ALU write to addr A (A!=0), every queued entry with addr==A has live cleared (squash).
//    An LSU result pushed in the same cycle with lsu_waddr==A is accepted and dropped.
//    A squashed head is still popped in its turn, giving we=0 for that cycle.
//  - pendN (combinational) = rawN!=0 & some live FIFO entry has addr==rawN.
//    The registered output stage is excluded: the register file forwards same-cycle we/wdata.
//  - Squash takes effect on pend the cycle after the ALU write is presented.
//  - Pointers wrap modulo DEPTH. Occupancy counter is clog2(DEPTH)+1 bits.
//    Full when count==DEPTH; empty when count==0.
// STRUCTURE
//  - Shared constants from defines.vh: `RegBus, `RegAddrBus, `RegNumLog2, `WriteEnable,
//    `WriteDisable, `RstEnable, `ZeroWord. Add `WbFifoDepth (4) there.
//  - One sub-module: wb_result_fifo (storage, pointers, count, per-entry live bits,
//    address-match squash port, two CAM lookup ports for pend).
//  - Top level: priority mux + output register.
// TESTING
//  1. Reset/idle: rst=1 for 2 cycles with lsu_valid=1 -> lsu_ready=0, we=0, waddr=0, wdata=0.
//  2. ALU only: alu_valid=1, alu_waddr=5, alu_wdata=32'hDEADBEEF -> next cycle we=1, waddr=5, wdata=DEADBEEF.
//     Then alu_waddr=0 -> we=0.
//  3. LSU priority: push LSU {r3,0x11} while ALU writes r7 for 3 cycles
//     -> r7 writes on 3 cycles, r3 on the 4th; pend for r3=1 until its pop cycle.
//  4. Full: push 4 LSU results (r1..r4) while ALU busy -> lsu_ready=0 at count 4.
//     After ALU stops, drain order r1,r2,r3,r4 on consecutive cycles; lsu_ready=1 after the first pop.
//  5. Squash: queue {r9,0xA}, then ALU writes {r9,0xB}
//     -> we writes r9=0xB; later pop gives we=0; pend(r9)=0 after the ALU cycle.
//     Simultaneous push {r9,0xC} with ALU r9 -> accepted, never written.
//  6. Reset mid-drain: 3 entries queued, rst pulse -> all discarded, we=0, no stale writes afterwards.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_wb_ctrl_pkg: shared widths, write-enable levels and write-back source select for the register-file write port.
package regfile_wb_ctrl_pkg;

    localparam int REG_BUS       = 32;
    localparam int REG_NUM_LOG2  = 5;
    localparam int WB_FIFO_DEPTH = 4;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_FIFO
    } wb_sel_e;

endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: long-latency result queue with per-entry live bits, address squash and two CAM lookups.
module wb_result_fifo
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_NUM_LOG2,
    parameter int DEPTH  = WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [ADDR_W-1:0] squash_addr,
    input  logic [ADDR_W-1:0] lookup1,
    input  logic [ADDR_W-1:0] lookup2,
    output logic              full,
    output logic              empty,
    output logic              head_live,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              hit1,
    output logic              hit2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    assign full      = cnt_q == CW'(DEPTH);
    assign empty     = cnt_q == '0;
    assign head_live = live_q[rd_q];
    assign head_addr = addr_q[rd_q];
    assign head_data = data_q[rd_q];

    // A live bit is only ever set on a pushed, not-yet-popped entry, so live alone marks a pending write.
    always_comb begin
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        live_d = live_q;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < DEPTH; i++)
            if (squash_en && addr_q[i] == squash_addr) live_d[i] = 1'b0;
        if (pop) live_d[rd_q] = 1'b0;
        if (push) begin
            live_d[wr_q] = 1'b1;
            addr_d[wr_q] = push_addr;
            data_d[wr_q] = push_data;
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | (live_q[i] & (addr_q[i] == lookup1));
            hit2 = hit2 | (live_q[i] & (addr_q[i] == lookup2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            live_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            live_q <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU (priority) and queued long-latency results onto the register-file write port.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_NUM_LOG2,
    parameter int DEPTH  = WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              pend1,
    output logic              pend2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    logic              alu_wr, push, pop, full, empty, head_live, hit1, hit2;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    wb_sel_e           sel;

    assign alu_wr    = alu_valid & (alu_waddr != '0);
    assign lsu_ready = !rst & !full;
    // A same-cycle LSU result to the ALU's target is older than the ALU write, so it is dropped at the door.
    assign push      = lsu_valid & lsu_ready & (lsu_waddr != '0) & !(alu_wr & (lsu_waddr == alu_waddr));
    assign pop       = sel == SEL_FIFO;
    assign pend1     = (raddr1 != '0) & hit1;
    assign pend2     = (raddr2 != '0) & hit2;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;

    always_comb begin
        sel     = alu_wr ? SEL_ALU : !empty ? SEL_FIFO : SEL_NONE;
        we_d    = sel == SEL_ALU ? WRITE_ENABLE : sel == SEL_FIFO ? head_live : WRITE_DISABLE;
        waddr_d = sel == SEL_ALU ? alu_waddr : sel == SEL_FIFO ? head_addr : waddr_q;
        wdata_d = sel == SEL_ALU ? alu_wdata : sel == SEL_FIFO ? head_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= WRITE_DISABLE;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    wb_result_fifo #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (lsu_waddr),
        .push_data  (lsu_wdata),
        .pop        (pop),
        .squash_en  (alu_wr),
        .squash_addr(alu_waddr),
        .lookup1    (raddr1),
        .lookup2    (raddr2),
        .full       (full),
        .empty      (empty),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .hit1       (hit1),
        .hit2       (hit2)
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed scenario tasks for the write-back controller with hand-computed expectations.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, lsu_ready, pend1, pend2, we;
    logic [4:0]  alu_waddr, lsu_waddr, raddr1, raddr2, waddr;
    logic [31:0] alu_wdata, lsu_wdata, wdata;
    int          n_cmp = 0;
    int          n_bad = 0;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h1; raddr1 = 5'd3;
        step(); step();
        n_cmp++; if (lsu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", lsu_ready); end
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", we); end
        n_cmp++; if (waddr !== 5'd0) begin n_bad++; $display("FAIL rst_waddr got %0d want 0", waddr); end
        n_cmp++; if (wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", wdata); end
        n_cmp++; if (pend1 !== 1'b0) begin n_bad++; $display("FAIL rst_pend got %b want 0", pend1); end
        rst = 1'b0; lsu_valid = 1'b0;
        #1;
        n_cmp++; if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got %b want 1", lsu_ready); end
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL idle_we got %b want 0", we); end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
        step();
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_write got we=%b %0d/%h want 1 5/deadbeef", we, waddr, wdata); end
        alu_waddr = 5'd0; alu_wdata = 32'h12345678;
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL alu_r0 got we=%b want 0", we); end
        n_cmp++; if (waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_hold got %0d/%h want 5/deadbeef", waddr, wdata); end
        alu_valid = 1'b0;
    endtask

    task automatic test_priority();
        alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h70;
        lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h11; raddr1 = 5'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            lsu_valid = 1'b0;
            if (i == 2) alu_valid = 1'b0;
            #1;
            n_cmp++; if (we !== 1'b1 || waddr !== 5'd7) begin n_bad++; $display("FAIL prio_alu%0d got we=%b r%0d want 1 r7", i, we, waddr); end
            n_cmp++; if (pend1 !== 1'b1) begin n_bad++; $display("FAIL prio_pend%0d got %b want 1", i, pend1); end
        end
        step();
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h11) begin n_bad++; $display("FAIL prio_lsu got we=%b %0d/%h want 1 3/11", we, waddr, wdata); end
        n_cmp++; if (pend1 !== 1'b0) begin n_bad++; $display("FAIL prio_pend_clear got %b want 0", pend1); end
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL prio_idle got we=%b want 0", we); end
    endtask

    task automatic test_full();
        alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h77; raddr2 = 5'd2;
        for (int i = 1; i <= 4; i++) begin
            lsu_valid = 1'b1; lsu_waddr = 5'(i); lsu_wdata = 32'h100 + 32'(i);
            #1;
            n_cmp++; if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready%0d got %b want 1", i, lsu_ready); end
            step();
        end
        lsu_valid = 1'b0;
        #1;
        n_cmp++; if (lsu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", lsu_ready); end
        n_cmp++; if (pend2 !== 1'b1) begin n_bad++; $display("FAIL full_pend2 got %b want 1", pend2); end
        alu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++; if (we !== 1'b1 || waddr !== 5'(i) || wdata !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL drain%0d got we=%b %0d/%h want 1 %0d/%h", i, we, waddr, wdata, i, 32'h100 + 32'(i)); end
            if (i == 1) begin
                n_cmp++; if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready got %b want 1", lsu_ready); end
            end
        end
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL drain_idle got we=%b want 0", we); end
    endtask

    task automatic test_squash();
        alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h0;
        lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'hA; raddr1 = 5'd9;
        step();
        #1;
        n_cmp++; if (pend1 !== 1'b1) begin n_bad++; $display("FAIL sq_pend_before got %b want 1", pend1); end
        alu_waddr = 5'd9; alu_wdata = 32'hB; lsu_wdata = 32'hC;
        #1;
        n_cmp++; if (lsu_ready !== 1'b1) begin n_bad++; $display("FAIL sq_ready got %b want 1", lsu_ready); end
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'hB) begin n_bad++; $display("FAIL sq_alu got we=%b %0d/%h want 1 9/b", we, waddr, wdata); end
        n_cmp++; if (pend1 !== 1'b0) begin n_bad++; $display("FAIL sq_pend_after got %b want 0", pend1); end
        step();
        n_cmp++; if (we !== 1'b0 || wdata !== 32'hA) begin n_bad++; $display("FAIL sq_pop got we=%b data=%h want 0 a", we, wdata); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL sq_stale%0d got we=%b r%0d data=%h want 0", i, we, waddr, wdata); end
        end
    endtask

    task automatic test_reset_mid_drain();
        alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h7; raddr1 = 5'd4;
        for (int i = 1; i <= 3; i++) begin
            lsu_valid = 1'b1; lsu_waddr = 5'(2 * i); lsu_wdata = 32'h200 + 32'(i);
            step();
        end
        lsu_valid = 1'b0; alu_valid = 1'b0;
        step();
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd2) begin n_bad++; $display("FAIL mid_first got we=%b r%0d want 1 r2", we, waddr); end
        rst = 1'b1;
        step();
        n_cmp++; if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'h0) begin n_bad++; $display("FAIL mid_rst got we=%b %0d/%h want 0 0/0", we, waddr, wdata); end
        n_cmp++; if (lsu_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready got %b want 0", lsu_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (pend1 !== 1'b0) begin n_bad++; $display("FAIL mid_pend got %b want 0", pend1); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL mid_stale%0d got we=%b r%0d want 0", i, we, waddr); end
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0; raddr1 = '0; raddr2 = '0;
        test_reset();
        test_alu();
        test_priority();
        test_full();
        test_squash();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
